// File: rtl/seq_det_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_det_pkg : shared defaults for the serial sequence detector       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seq_det_pkg;

  localparam int unsigned          C_PAT_LEN = 4;
  localparam int unsigned          C_CNT_W   = 8;
  localparam logic [C_PAT_LEN-1:0] C_RST_PAT = 4'b1011;

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : saturating event counter with sticky all-ones flag     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] c_max = '1;

  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic [CNT_W-1:0] w_next;

  assign w_next = r_count + CNT_W'(1);

  // Clear takes effect before the increment of the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (clr) begin
      r_count <= CNT_W'(inc);
      r_sat   <= 1'b0;
    end else if (inc && (r_count != c_max)) begin
      r_count <= w_next;
      if (&w_next) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign count = r_count;
  assign sat   = r_sat;

endmodule : sat_counter
`default_nettype wire

// File: rtl/param_sequence_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_sequence_detector : programmable serial bit-pattern detector   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module param_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned         PAT_LEN = C_PAT_LEN,
  parameter int unsigned         CNT_W   = C_CNT_W,
  parameter logic [PAT_LEN-1:0]  RST_PAT = PAT_LEN'(C_RST_PAT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic               pattern_load,
  input  logic [PAT_LEN-1:0] pattern_in,
  input  logic               overlap_en,
  input  logic               cnt_clear,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam int unsigned         FILL_W      = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]   c_fill_thr  = FILL_W'(PAT_LEN - 1);
  localparam logic [FILL_W-1:0]   c_fill_full = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] r_pattern;
  logic [PAT_LEN-2:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_detected;

  logic               w_accept;
  logic [PAT_LEN-1:0] w_window;
  logic               w_match;

  // A pattern load swallows any bit presented on the same edge.
  assign w_accept = bit_valid & ~pattern_load;
  assign w_window = {r_hist, bit_in};
  assign w_match  = w_accept && (r_fill >= c_fill_thr) && (w_window == r_pattern);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pattern <= RST_PAT;
      r_hist    <= '0;
      r_fill    <= '0;
    end else if (pattern_load) begin
      r_pattern <= pattern_in;
      r_fill    <= '0;
    end else if (bit_valid) begin
      r_hist <= w_window[PAT_LEN-2:0];
      if (w_match && !overlap_en) begin
        r_fill <= '0;
      end else if (r_fill != c_fill_full) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_detected <= 1'b0;
    end else begin
      r_detected <= w_match;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (w_match),
    .clr   (cnt_clear),
    .count (match_count),
    .sat   (count_sat)
  );

  assign detected = r_detected;

endmodule : param_sequence_detector
`default_nettype wire

// File: tb/tb_param_sequence_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_param_sequence_detector : scoreboard bench, 8-bit and 2-bit count |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_param_sequence_detector;
  import seq_det_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       pattern_load = 1'b0;
  logic [3:0] pattern_in = 4'b0000;
  logic       overlap_en = 1'b1;
  logic       cnt_clear = 1'b0;

  logic       det8, sat8, det2, sat2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       det;
    logic [7:0] c8;
    logic       s8;
    logic [1:0] c2;
    logic       s2;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] m_c8 = '0;
  logic       m_s8 = 1'b0;
  logic [1:0] m_c2 = '0;
  logic       m_s2 = 1'b0;

  always #5 clk = ~clk;

  param_sequence_detector #(
    .PAT_LEN (C_PAT_LEN),
    .CNT_W   (8),
    .RST_PAT (C_RST_PAT)
  ) dut8 (
    .clk (clk), .reset (reset), .bit_valid (bit_valid), .bit_in (bit_in),
    .pattern_load (pattern_load), .pattern_in (pattern_in),
    .overlap_en (overlap_en), .cnt_clear (cnt_clear),
    .detected (det8), .match_count (cnt8), .count_sat (sat8)
  );

  param_sequence_detector #(
    .PAT_LEN (C_PAT_LEN),
    .CNT_W   (2),
    .RST_PAT (C_RST_PAT)
  ) dut2 (
    .clk (clk), .reset (reset), .bit_valid (bit_valid), .bit_in (bit_in),
    .pattern_load (pattern_load), .pattern_in (pattern_in),
    .overlap_en (overlap_en), .cnt_clear (cnt_clear),
    .detected (det2), .match_count (cnt2), .count_sat (sat2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; exp_det is the hand-derived detected value.
  task automatic step(input logic v, input logic b, input logic ld, input logic [3:0] p,
                      input logic ovl, input logic clr, input logic exp_det);
    exp_t e;
    @(negedge clk);
    bit_valid = v; bit_in = b; pattern_load = ld; pattern_in = p;
    overlap_en = ovl; cnt_clear = clr;
    @(posedge clk);
    if (clr) begin
      m_c8 = {7'd0, exp_det}; m_s8 = 1'b0;
      m_c2 = {1'b0, exp_det}; m_s2 = 1'b0;
    end else if (exp_det) begin
      if (m_c8 != 8'hff) m_c8 = m_c8 + 8'd1;
      if (m_c8 == 8'hff) m_s8 = 1'b1;
      if (m_c2 != 2'b11) m_c2 = m_c2 + 2'd1;
      if (m_c2 == 2'b11) m_s2 = 1'b1;
    end
    e.det = exp_det; e.c8 = m_c8; e.s8 = m_s8; e.c2 = m_c2; e.s2 = m_s2;
    exp_q.push_back(e);
    #1;
    bit_valid = 1'b0; pattern_load = 1'b0; cnt_clear = 1'b0;
  endtask

  // Feed n bits MSB-first from bits, expecting pulses where dets has a 1.
  task automatic feed(input int n, input logic [15:0] bits, input logic [15:0] dets,
                      input logic ovl);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, 4'b0000, ovl, 1'b0, dets[i]);
    end
  endtask

  task automatic load(input logic [3:0] p, input logic ovl);
    step(1'b0, 1'b0, 1'b1, p, ovl, 1'b1, 1'b0);
  endtask

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] req);
    #1;
    check(name, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_det8", {31'd0, det8}, {31'd0, e.det});
      check("sb_det2", {31'd0, det2}, {31'd0, e.det});
      check("sb_cnt8", {24'd0, cnt8}, {24'd0, e.c8});
      check("sb_sat8", {31'd0, sat8}, {31'd0, e.s8});
      check("sb_cnt2", {30'd0, cnt2}, {30'd0, e.c2});
      check("sb_sat2", {31'd0, sat2}, {31'd0, e.s2});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    check("rst_det", {31'd0, det8 | det2}, 32'd0);
    check("rst_cnt8", {24'd0, cnt8}, 32'd0);
    check("rst_cnt2", {30'd0, cnt2}, 32'd0);
    check("rst_sat", {31'd0, sat8 | sat2}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // 1: overlapping, reset pattern 1011
    feed(7, 16'b1011011, 16'b0001001, 1'b1);
    check_now("t1_count", {24'd0, cnt8}, 32'd2);

    // 2: non-overlapping needs fresh bits after a match
    load(4'b1011, 1'b0);
    feed(7, 16'b1011011, 16'b0001000, 1'b0);
    feed(4, 16'b1011, 16'b0001, 1'b0);
    check_now("t2_count", {24'd0, cnt8}, 32'd2);

    // 3: gaps in bit_valid do not break the match
    load(4'b1011, 1'b1);
    feed(2, 16'b10, 16'b00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    feed(2, 16'b11, 16'b01, 1'b1);
    check_now("t3_count", {24'd0, cnt8}, 32'd1);

    // 4: load discards concurrent bit; old pattern then ignored
    load(4'b1011, 1'b1);
    feed(3, 16'b101, 16'b000, 1'b1);
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
    feed(4, 16'b0110, 16'b0001, 1'b1);
    feed(2, 16'b11, 16'b00, 1'b1);
    check_now("t4_count", {24'd0, cnt8}, 32'd1);

    // 5: 2-bit counter saturation, then clear coinciding with a match
    load(4'b1011, 1'b1);
    feed(4, 16'b1011, 16'b0001, 1'b1);
    check_now("t5_c2_m1", {30'd0, cnt2}, 32'd1);
    feed(3, 16'b011, 16'b001, 1'b1);
    check_now("t5_c2_m2", {30'd0, cnt2}, 32'd2);
    check_now("t5_s2_m2", {31'd0, sat2}, 32'd0);
    feed(3, 16'b011, 16'b001, 1'b1);
    check_now("t5_c2_m3", {30'd0, cnt2}, 32'd3);
    check_now("t5_s2_m3", {31'd0, sat2}, 32'd1);
    feed(3, 16'b011, 16'b001, 1'b1);
    feed(3, 16'b011, 16'b001, 1'b1);
    check_now("t5_c2_m5", {30'd0, cnt2}, 32'd3);
    check_now("t5_c8_m5", {24'd0, cnt8}, 32'd5);
    feed(2, 16'b01, 16'b00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
    check_now("t5_c2_clr", {30'd0, cnt2}, 32'd1);
    check_now("t5_s2_clr", {31'd0, sat2}, 32'd0);

    // 6: reset mid-stream flushes history
    feed(3, 16'b101, 16'b000, 1'b1);
    @(negedge clk); #1;
    reset = 1'b1;
    m_c8 = '0; m_s8 = 1'b0; m_c2 = '0; m_s2 = 1'b0;
    #1;
    check("t6_rst_det", {31'd0, det8 | det2}, 32'd0);
    check("t6_rst_cnt8", {24'd0, cnt8}, 32'd0);
    check("t6_rst_cnt2", {30'd0, cnt2}, 32'd0);
    check("t6_rst_sat", {31'd0, sat8 | sat2}, 32'd0);
    @(negedge clk); reset = 1'b0;
    feed(1, 16'b1, 16'b0, 1'b1);
    feed(4, 16'b1011, 16'b0001, 1'b1);
    check_now("t6_count", {24'd0, cnt8}, 32'd1);

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_param_sequence_detector
`default_nettype wire
